// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, the data port and the single-port memory side
// shared by the arbiter and whatever drives it.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // fetch port
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [DW-1:0] if_rdata;
  // data port
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  // pipeline stalls
  logic          stall_if;
  logic          stall_d;
  // memory side
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  // arbiter side
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_ack, if_rdata, d_ack, d_rdata, stall_if, stall_d,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  // requesters + memory side
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_ack, if_rdata, d_ack, d_rdata, stall_if, stall_d,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port (fetch / data) arbiter in front of a single-port synchronous
// memory. One access every two cycles: grant in IDLE, respond in RESP.
// Data has priority, but a pending fetch is forced through after
// MAX_D_BURST back-to-back data grants.
module mem_port_arbiter #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int MAX_D_BURST = 3
) (
  input logic              clk,
  input logic              reset,
  mem_port_arbiter_if.slave bus
);

  localparam int CW = (MAX_D_BURST < 1) ? 1 : $clog2(MAX_D_BURST + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_D_BURST);

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_e;

  state_e          state_q, state_d;
  logic            gnt_d_q, gnt_d_d;   // 1: data port owns the pending response
  logic [CW-1:0]   cnt_q,   cnt_d;     // data grants made while a fetch waited

  logic            fetch_win;
  logic            mem_en, mem_we, if_ack, d_ack;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata, if_rdata, d_rdata;

  // State, grantee and starvation counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_d_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_d_q <= gnt_d_d;
      cnt_q   <= cnt_d;
    end
  end

  // Grant selection, memory drive and response routing
  always_comb begin
    state_d   = state_q;
    gnt_d_d   = gnt_d_q;
    cnt_d     = cnt_q;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if_ack    = 1'b0;
    d_ack     = 1'b0;
    if_rdata  = '0;
    d_rdata   = '0;
    fetch_win = bus.if_req && (!bus.d_req || cnt_q == CNT_MAX);
    // Outputs stay quiet while reset is high; an ack due in RESP is dropped.
    if (!reset) begin
      unique case (state_q)
        IDLE: begin
          if (bus.if_req || bus.d_req) begin
            mem_en  = 1'b1;
            state_d = RESP;
            if (fetch_win) begin
              mem_addr = bus.if_addr;
              gnt_d_d  = 1'b0;
              cnt_d    = '0;
            end else begin
              mem_we    = bus.d_we;
              mem_addr  = bus.d_addr;
              mem_wdata = bus.d_wdata;
              gnt_d_d   = 1'b1;
              // Only grants that made a fetch wait count toward starvation.
              if (!bus.if_req)          cnt_d = '0;
              else if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
            end
          end
        end
        RESP: begin
          state_d = IDLE;
          if (gnt_d_q) begin
            d_ack   = 1'b1;
            d_rdata = bus.mem_rdata;
          end else begin
            if_ack   = 1'b1;
            if_rdata = bus.mem_rdata;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.mem_en    = mem_en;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.if_ack    = if_ack;
  assign bus.if_rdata  = if_rdata;
  assign bus.d_ack     = d_ack;
  assign bus.d_rdata   = d_rdata;
  assign bus.stall_if  = bus.if_req & ~if_ack;
  assign bus.stall_d   = bus.d_req & ~d_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench: two requesters and a 16-word memory drive the arbiter;
// a transaction-level reference model predicts every output each cycle.
module tb_mem_port_arbiter;

  localparam int MAXB   = 3;
  localparam int NCYC   = 4000;
  localparam int PHASE_A = 300;   // both ports always requesting
  localparam int RST_FROM = 2000; // random resets enabled after this

  logic clk = 1'b0;
  logic reset;
  logic mem_ready = 1'b0;
  logic [31:0] bmem [0:15];

  mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_port_arbiter #(.AW(32), .DW(32), .MAX_D_BURST(MAXB)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // environment memory: writes on grant, read data one cycle later
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 16; i++) bmem[i] <= 32'hC0DE_0000 + i;
      bus.mem_rdata <= '0;
      mem_ready     <= 1'b1;
    end else if (bus.mem_en) begin
      if (bus.mem_we) bmem[bus.mem_addr[5:2]] <= bus.mem_wdata;
      else            bus.mem_rdata <= bmem[bus.mem_addr[5:2]];
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // reference model: who owes a response, its data, and the starvation count
  logic [31:0] ref_mem [0:15];
  int          m_owed;      // 0 none, 1 fetch, 2 data
  bit          m_wr;
  logic [31:0] m_rdata;
  int          m_cnt;
  bit          saw_if, saw_d;
  int          n_fetch_gnt, n_data_gnt;

  task automatic model_check();
    logic exp_en, exp_we, exp_ia, exp_da;
    logic [31:0] exp_addr, exp_wd, exp_ir, exp_dr;
    bit skip_dr;
    exp_en = 0; exp_we = 0; exp_ia = 0; exp_da = 0;
    exp_addr = 0; exp_wd = 0; exp_ir = 0; exp_dr = 0;
    skip_dr = 0;
    if (reset) begin
      m_owed = 0;
      m_cnt  = 0;
    end else if (m_owed != 0) begin
      if (m_owed == 1) begin
        exp_ia = 1; exp_ir = m_rdata;
      end else begin
        exp_da = 1; exp_dr = m_rdata; skip_dr = m_wr;
      end
      m_owed = 0;
    end else if (bus.if_req || bus.d_req) begin
      exp_en = 1;
      if (bus.if_req && (!bus.d_req || m_cnt == MAXB)) begin
        exp_addr = bus.if_addr;
        m_rdata  = ref_mem[bus.if_addr[5:2]];
        m_owed   = 1;
        m_cnt    = 0;
        n_fetch_gnt++;
      end else begin
        exp_addr = bus.d_addr;
        exp_we   = bus.d_we;
        m_wr     = bus.d_we;
        if (bus.d_we) begin
          exp_wd = bus.d_wdata;
          ref_mem[bus.d_addr[5:2]] = bus.d_wdata;
        end else begin
          m_rdata = ref_mem[bus.d_addr[5:2]];
        end
        m_owed = 2;
        m_cnt  = bus.if_req ? ((m_cnt + 1 > MAXB) ? MAXB : m_cnt + 1) : 0;
        n_data_gnt++;
      end
    end
    chk("mem_en",   64'(bus.mem_en), 64'(exp_en));
    chk("mem_we",   64'(bus.mem_we), 64'(exp_we));
    if (exp_en) chk("mem_addr", 64'(bus.mem_addr), 64'(exp_addr));
    if (exp_we) chk("mem_wdata", 64'(bus.mem_wdata), 64'(exp_wd));
    chk("if_ack",   64'(bus.if_ack), 64'(exp_ia));
    chk("d_ack",    64'(bus.d_ack),  64'(exp_da));
    chk("if_rdata", 64'(bus.if_rdata), 64'(exp_ir));
    if (!skip_dr) chk("d_rdata", 64'(bus.d_rdata), 64'(exp_dr));
    chk("stall_if", 64'(bus.stall_if), 64'(bus.if_req & ~exp_ia));
    chk("stall_d",  64'(bus.stall_d),  64'(bus.d_req & ~exp_da));
    saw_if = exp_ia;
    saw_d  = exp_da;
  endtask

  task automatic new_d_req();
    bus.d_req   = 1'b1;
    bus.d_we    = 1'($urandom_range(0, 1));
    bus.d_addr  = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
    bus.d_wdata = $urandom;
  endtask

  task automatic drive(input int cyc);
    bit busy;
    busy  = (cyc < PHASE_A);
    reset = (cyc < 3) || (cyc >= RST_FROM && $urandom_range(0, 39) == 0);
    // fetch requester: step the address after each ack, sometimes drop
    if (bus.if_req) begin
      if (saw_if) begin
        if (busy || $urandom_range(0, 3) != 0) bus.if_addr = (bus.if_addr + 32'd4) & 32'h3C;
        else bus.if_req = 1'b0;
      end
    end else if (busy || $urandom_range(0, 2) == 0) begin
      bus.if_req  = 1'b1;
      bus.if_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
    end
    // data requester: fresh random access after each ack, sometimes drop
    if (bus.d_req) begin
      if (saw_d) begin
        if (busy || $urandom_range(0, 2) != 0) new_d_req();
        else bus.d_req = 1'b0;
      end
    end else if (busy || $urandom_range(0, 1) == 0) begin
      new_d_req();
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'hC0DE_0000 + i;
    m_owed = 0; m_wr = 0; m_rdata = 0; m_cnt = 0;
    saw_if = 0; saw_d = 0; n_fetch_gnt = 0; n_data_gnt = 0;
    reset       = 1'b1;
    bus.if_req  = 1'b0;
    bus.if_addr = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      model_check();
      @(posedge clk);
      #1;
      drive(cyc);
    end
    // both ports must have been served during the run
    chk("fetch_grants_seen", 64'(n_fetch_gnt > 100), 64'd1);
    chk("data_grants_seen",  64'(n_data_gnt > 100),  64'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
